// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream
//   AES-256 counter-mode keystream sequencer. Accepts a job (key, nonce,
//   starting counter, block count), issues batches of LANES counter blocks
//   to an external AES engine and streams the returned keystream out
//   over a valid/ready interface, one batch per beat.
//
// Parameters
//   LANES  parallel AES lanes per batch (1..8)
//   CTR_W  counter field width; nonce is 128-CTR_W bits
//   LEN_W  width of the requested block count
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 job request, sampled only in IDLE
//   key/nonce/ctr_init    job parameters, captured on accepted start
//   num_blocks            number of 128-bit blocks to produce
//   busy, done            not-idle flag, one-cycle completion pulse
//   eng_start/key/iv      request side of the AES engine
//   eng_done/eng_ct       engine response (ct valid with eng_done)
//   out_valid/ready/data  keystream stream, lane 0 in the MSBs
//   out_keep/out_last     per-lane valid mask, final-batch flag
//
// Optional feature
//   AES_CTR_STREAM_PREFETCH_EN  adds a second output buffer so the next
//   batch is fetched while the current one waits for out_ready.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// ISSUE  | eng_start asserted for one cycle
// WAIT   | engine working; eng_done pushes the batch into the buffer
// OUT    | engine idle, waiting for the output buffer to drain
// FIN    | job finished; done is pulsed on the way back to IDLE

module aes_ctr_stream #(
  parameter int LANES = 4,
  parameter int CTR_W = 32,
  parameter int LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [255:0]           key,
  input  logic [127-CTR_W:0]     nonce,
  input  logic [CTR_W-1:0]       ctr_init,
  input  logic [LEN_W-1:0]       num_blocks,
  output logic                   busy,
  output logic                   done,
  output logic                   eng_start,
  output logic [255:0]           eng_key,
  output logic [LANES*128-1:0]   eng_iv,
  input  logic                   eng_done,
  input  logic [LANES*128-1:0]   eng_ct,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*128-1:0]   out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_last
);

  localparam int NONCE_W = 128 - CTR_W;

`ifdef AES_CTR_STREAM_PREFETCH_EN
  localparam logic [1:0] BUF_DEPTH = 2'd2;
`else
  localparam logic [1:0] BUF_DEPTH = 2'd1;
`endif

  localparam logic [LEN_W-1:0] LANES_LEN = LEN_W'(LANES);
  localparam logic [CTR_W-1:0] LANES_CTR = CTR_W'(LANES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [NONCE_W-1:0]     nonce_q;
  logic [CTR_W-1:0]       ctr_q;
  logic [LEN_W-1:0]       rem_q;
  logic                   done_q;
  logic [1:0]             cnt_q;
  logic [1:0]             cnt_after;
  logic [LEN_W-1:0]       take;
  logic [LEN_W-1:0]       rem_after;
  logic                   accept;
  logic                   push;
  logic                   pop;

  // Head of the output buffer; this is what the stream presents.
  logic [LANES*128-1:0]   buf0_data;
  logic [LANES-1:0]       buf0_keep;
  logic                   buf0_last;
`ifdef AES_CTR_STREAM_PREFETCH_EN
  logic [LANES*128-1:0]   buf1_data;
  logic [LANES-1:0]       buf1_keep;
  logic                   buf1_last;
`endif

  // Lane i carries {nonce, ctr+i}, lane 0 in the MSBs; the counter wraps.
  function automatic logic [LANES*128-1:0] build_iv(
    input logic [NONCE_W-1:0] n,
    input logic [CTR_W-1:0]   c
  );
    logic [LANES*128-1:0] iv;
    iv = '0;
    for (int i = 0; i < LANES; i++) begin
      iv[(LANES-1-i)*128 +: 128] = {n, c + CTR_W'(i)};
    end
    return iv;
  endfunction

  function automatic logic [LANES-1:0] keep_for(input logic [LEN_W-1:0] r);
    logic [LANES-1:0] k;
    k = '0;
    for (int i = 0; i < LANES; i++) begin
      k[LANES-1-i] = (r > LEN_W'(i));
    end
    return k;
  endfunction

  assign accept    = (state_q == S_IDLE) && start;
  assign push      = (state_q == S_WAIT) && eng_done;
  assign pop       = out_valid && out_ready;
  assign take      = (rem_q <= LANES_LEN) ? rem_q : LANES_LEN;
  assign rem_after = rem_q - take;
  assign cnt_after = cnt_q + {1'b0, push} - {1'b0, pop};

  assign busy      = (state_q != S_IDLE);
  assign eng_start = (state_q == S_ISSUE);
  assign done      = done_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf0_data;
  assign out_keep  = out_valid ? buf0_keep : '0;
  assign out_last  = out_valid && buf0_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // rem_q counts blocks not yet fetched from the engine. Without prefetch a
  // batch is fetched only after the previous one left OUT, so it equals the
  // remainder of the batch on display and keep/last come out the same.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_blocks != '0) ? S_ISSUE : S_FIN;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          if ((rem_after != '0) && (cnt_after < BUF_DEPTH)) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (pop) begin
          if (rem_q != '0) begin
            state_d = S_ISSUE;
          end else if (cnt_after == 2'd0) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      nonce_q   <= '0;
      ctr_q     <= '0;
      rem_q     <= '0;
      eng_key   <= '0;
      eng_iv    <= '0;
      cnt_q     <= 2'd0;
      buf0_data <= '0;
      buf0_keep <= '0;
      buf0_last <= 1'b0;
`ifdef AES_CTR_STREAM_PREFETCH_EN
      buf1_data <= '0;
      buf1_keep <= '0;
      buf1_last <= 1'b0;
`endif
    end else begin
      // Registered so done lands in the cycle after FIN, with busy low.
      done_q <= (state_q == S_FIN);

      if (accept) begin
        eng_key <= key;
        nonce_q <= nonce;
        ctr_q   <= ctr_init;
        rem_q   <= num_blocks;
        eng_iv  <= build_iv(nonce, ctr_init);
      end

      // The IV is advanced only once the engine has returned, so it stays
      // stable for the whole time the engine is working on it.
      if (push) begin
        ctr_q  <= ctr_q + LANES_CTR;
        rem_q  <= rem_after;
        eng_iv <= build_iv(nonce_q, ctr_q + LANES_CTR);
      end

`ifdef AES_CTR_STREAM_PREFETCH_EN
      if (pop && (cnt_q == 2'd2)) begin
        buf0_data <= buf1_data;
        buf0_keep <= buf1_keep;
        buf0_last <= buf1_last;
      end
`endif

      // At most one entry is held when the engine returns, so a push goes
      // to the head when it is empty or being popped, otherwise behind it.
      if (push) begin
        if ((cnt_q == 2'd0) || pop) begin
          buf0_data <= eng_ct;
          buf0_keep <= keep_for(rem_q);
          buf0_last <= (rem_q <= LANES_LEN);
        end
`ifdef AES_CTR_STREAM_PREFETCH_EN
        else begin
          buf1_data <= eng_ct;
          buf1_keep <= keep_for(rem_q);
          buf1_last <= (rem_q <= LANES_LEN);
        end
`endif
      end

      cnt_q <= cnt_after;
    end
  end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb_aes_ctr_stream
//   Self-checking bench for aes_ctr_stream (LANES=4, CTR_W=32, LEN_W=16).
//   A toy engine model answers eng_start after a random delay; expected
//   IVs, keystream beats, keep masks and last flags are computed per job
//   from the counter-mode rules and compared with the DUT.

module tb_aes_ctr_stream;

  localparam int LANES = 4;
  localparam int CTR_W = 32;
  localparam int LEN_W = 16;

`ifdef AES_CTR_STREAM_PREFETCH_EN
  localparam int STALL_STARTS = 1;
`else
  localparam int STALL_STARTS = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [255:0]          key;
  logic [127-CTR_W:0]    nonce;
  logic [CTR_W-1:0]      ctr_init;
  logic [LEN_W-1:0]      num_blocks;
  logic                  busy;
  logic                  done;
  logic                  eng_start;
  logic [255:0]          eng_key;
  logic [LANES*128-1:0]  eng_iv;
  logic                  eng_done;
  logic [LANES*128-1:0]  eng_ct;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*128-1:0]  out_data;
  logic [LANES-1:0]      out_keep;
  logic                  out_last;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_ctr_stream #(
    .LANES(LANES),
    .CTR_W(CTR_W),
    .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .key(key),
    .nonce(nonce),
    .ctr_init(ctr_init),
    .num_blocks(num_blocks),
    .busy(busy),
    .done(done),
    .eng_start(eng_start),
    .eng_key(eng_key),
    .eng_iv(eng_iv),
    .eng_done(eng_done),
    .eng_ct(eng_ct),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_keep(out_keep),
    .out_last(out_last)
  );

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Stand-in for the AES engine: any fixed keyed mapping will do.
  function automatic logic [511:0] fake_aes(input logic [511:0] iv, input logic [255:0] k);
    return iv ^ {4{k[255:128] ^ k[127:0]}};
  endfunction

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctrl"}, 512'({busy, done, eng_start, out_valid, out_last, out_keep}), 512'(0));
    check_eq({tag, "_out_data"}, out_data, 512'(0));
    check_eq({tag, "_eng_iv"}, eng_iv, 512'(0));
    check_eq({tag, "_eng_key"}, 512'(eng_key), 512'(0));
  endtask

  task automatic run_job(input logic [15:0] n, input logic [31:0] ci, input int rdy_pct, input bit stall);
    logic [511:0] q_iv[$];
    logic [511:0] q_data[$];
    logic [3:0]   q_keep[$];
    logic         q_last[$];
    logic [255:0] k;
    logic [255:0] lat_key;
    logic [95:0]  nc;
    logic [511:0] lat_iv;
    int cyc, dones, eng_wait, stall_left, stall_starts, stall_expect;
    bit eng_pend, want_valid;

    k  = 256'(rand512());
    nc = 96'(rand512());
    lat_iv  = '0;
    lat_key = '0;
    for (int b = 0; 4*b < int'(n); b++) begin
      logic [511:0] iv;
      logic [3:0]   kp;
      int r;
      r = int'(n) - 4*b;
      for (int i = 0; i < 4; i++) begin
        iv[(3-i)*128 +: 128] = {nc, ci + 32'(4*b + i)};
        kp[3-i] = (i < r);
      end
      q_iv.push_back(iv);
      q_data.push_back(fake_aes(iv, k));
      q_keep.push_back(kp);
      q_last.push_back(r <= 4);
    end

    key = k; nonce = nc; ctr_init = ci; num_blocks = n; start = 1'b1;
    cyc = 0; dones = 0; eng_pend = 0; want_valid = 0; eng_wait = 0;
    stall_left   = stall ? 10 : 0;
    stall_starts = 0;
    stall_expect = (n > 16'd4) ? STALL_STARTS : 0;

    while (dones == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check_eq("busy_after_start", 512'(busy), 512'(1));
        check_eq("start_to_eng_start", 512'(eng_start), 512'(n != 16'd0));
      end
      if (want_valid) check_eq("eng_done_to_valid", 512'(out_valid), 512'(1));
      want_valid = 0;
      if (done) begin
        dones++;
        if (n == 16'd0) check_eq("zero_done_latency", 512'(cyc), 512'(2));
      end

      if (out_valid) begin
        if (q_data.size() == 0) check_eq("spurious_valid", 512'(out_valid), 512'(0));
        else begin
          check_eq("out_data", out_data, q_data[0]);
          check_eq("out_keep", 512'(out_keep), 512'(q_keep[0]));
          check_eq("out_last", 512'(out_last), 512'(q_last[0]));
        end
      end else begin
        check_eq("last_without_valid", 512'(out_last), 512'(0));
      end

      if (stall_left > 0 && out_valid) begin
        out_ready = 1'b0;
        if (eng_start) stall_starts++;
        stall_left--;
        if (stall_left == 0) check_eq("starts_during_stall", 512'(stall_starts), 512'(stall_expect));
      end else begin
        out_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      if (out_valid && out_ready && q_data.size() > 0) begin
        void'(q_data.pop_front());
        void'(q_keep.pop_front());
        void'(q_last.pop_front());
      end

      eng_done = 1'b0;
      eng_ct   = rand512();
      if (eng_pend) begin
        if (eng_wait == 0) begin
          eng_done   = 1'b1;
          eng_ct     = fake_aes(lat_iv, lat_key);
          eng_pend   = 0;
          want_valid = 1;
        end else begin
          eng_wait--;
        end
      end
      if (eng_start) begin
        if (q_iv.size() == 0 || eng_pend) check_eq("spurious_eng_start", 512'(eng_start), 512'(0));
        else begin
          check_eq("eng_iv", eng_iv, q_iv[0]);
          check_eq("eng_key", 512'(eng_key), 512'(k));
          void'(q_iv.pop_front());
        end
        lat_iv   = eng_iv;
        lat_key  = eng_key;
        eng_pend = 1;
        eng_wait = int'($urandom_range(0, 4));
      end else if (!eng_pend && !eng_done && $urandom_range(0, 7) == 0) begin
        eng_done = 1'b1;
      end

      if (busy && $urandom_range(0, 7) == 0) begin
        start      = 1'b1;
        num_blocks = 16'($urandom);
        ctr_init   = $urandom;
        key        = 256'(rand512());
        nonce      = 96'(rand512());
      end else begin
        start = 1'b0;
      end
    end

    start = 1'b0;
    eng_done = 1'b0;
    check_eq("job_done", 512'(dones), 512'(1));
    check_eq("batches_drained", 512'(q_data.size()), 512'(0));
    check_eq("ivs_issued", 512'(q_iv.size()), 512'(0));
    @(posedge clk); #1;
    check_eq("idle_after_done", 512'(busy), 512'(0));
    check_eq("done_one_cycle", 512'(done), 512'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key = '0; nonce = '0; ctr_init = '0;
    num_blocks = '0; eng_done = 1'b0; eng_ct = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst_n = 1'b1;

    run_job(16'd8, 32'h0, 100, 0);
    run_job(16'd6, 32'h10, 100, 0);
    run_job(16'd0, 32'h20, 100, 0);
    run_job(16'd4, 32'hFFFF_FFFE, 100, 0);
    run_job(16'd8, 32'h100, 100, 1);

    // Reset while the engine is working, then a late eng_done.
    key = 256'(rand512()); nonce = 96'(rand512()); ctr_init = 32'h55;
    num_blocks = 16'd8; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("rst_test_issue", 512'(eng_start), 512'(1));
    @(posedge clk); #1;
    check_eq("rst_test_wait_busy", 512'({busy, eng_start}), 512'(2'b10));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outs("mid_reset");
    rst_n = 1'b1; eng_done = 1'b1; eng_ct = rand512();
    @(posedge clk); #1;
    eng_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_eq("late_eng_done_ignored", 512'({busy, out_valid, done, eng_start}), 512'(0));
      @(posedge clk); #1;
    end

    for (int j = 0; j < 14; j++) begin
      run_job(16'($urandom_range(0, 14)),
              ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFF_FFFF - 32'($urandom_range(0, 9))),
              int'($urandom_range(30, 100)),
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
